// File: rtl/nibble_add_sequencer.sv
// Wide add/subtract built from one shared 4-bit ripple slice, one nibble per cycle, LSB first.
// Operands arrive on a valid/ready handshake; the full-width result leaves on another.

module bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c0;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c4 = c[4];

endmodule

module nibble_add_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   SUB,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   S,
  output logic                   CO,
  output logic                   OVF
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic            a_msb_q;
  logic            b_msb_q;
  logic            ovf_q;

  logic [W-1:0]    b_eff;
  logic [3:0]      sum;
  logic            sum_c4;

  // Subtraction is A + ~B + 1: invert B up front and seed the carry with SUB.
  assign b_eff = SUB ? ~B : B;

  bit_adder u_adder (
    .a  (a_q[4*idx_q +: 4]),
    .b  (b_q[4*idx_q +: 4]),
    .c0 (carry_q),
    .s  (sum),
    .c4 (sum_c4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= b_eff;
            carry_q <= SUB;
            idx_q   <= '0;
            a_msb_q <= A[W-1];
            b_msb_q <= b_eff[W-1];
            state_q <= StRun;
          end
        end
        StRun: begin
          res_q[4*idx_q +: 4] <= sum;
          carry_q             <= sum_c4;
          if (idx_q == LastIdx) begin
            idx_q   <= '0;
            // The top nibble's sum bit is the final result MSB.
            ovf_q   <= (a_msb_q == b_msb_q) & (sum[3] != a_msb_q);
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) & ~rst;
  assign out_valid = (state_q == StDone);
  assign S         = res_q;
  assign CO        = carry_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed bench for nibble_add_sequencer (NIBBLES = 4) with hand-computed expectations.

module tb_nibble_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        SUB;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        CO;
  logic        OVF;

  int passed;
  int total;

  nibble_add_sequencer #(
    .NIBBLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .CO        (CO),
    .OVF       (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive an operation at the current negedge; returns one negedge after the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub);
    A        = a;
    B        = b;
    SUB      = sub;
    in_valid = 1'b1;
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    A        = ~a;
    B        = ~b;
    SUB      = ~sub;
  endtask

  // Expects out_valid 4 edges after the accept edge; optionally completes the handshake.
  task automatic wait_done(input string tag, input logic [15:0] es, input logic eco,
                           input logic eovf, input logic ack);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 32'd4);
    check({tag, "_S"}, {16'b0, S}, {16'b0, es});
    check({tag, "_CO"}, {31'b0, CO}, {31'b0, eco});
    check({tag, "_OVF"}, {31'b0, OVF}, {31'b0, eovf});
    if (ack) begin
      @(negedge clk);
      check({tag, "_released"}, {31'b0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    bit seen;
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    SUB       = 1'b0;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_S", {16'b0, S}, 32'h0000);
    check("rst_CO", {31'b0, CO}, 32'd0);
    check("rst_OVF", {31'b0, OVF}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic add and carry/overflow corners
    issue(16'h1234, 16'h0FFF, 1'b0);
    wait_done("add_1234_0fff", 16'h2233, 1'b0, 1'b0, 1'b1);
    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_done("add_ffff_0001", 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(16'h7FFF, 16'h0001, 1'b0);
    wait_done("add_7fff_0001", 16'h8000, 1'b0, 1'b1, 1'b1);

    // Subtract
    issue(16'h0005, 16'h0007, 1'b1);
    wait_done("sub_0005_0007", 16'hFFFE, 1'b0, 1'b0, 1'b1);
    issue(16'h8000, 16'h0001, 1'b1);
    wait_done("sub_8000_0001", 16'h7FFF, 1'b1, 1'b1, 1'b1);

    // Backpressure with a competing second request
    out_ready = 1'b0;
    issue(16'h4321, 16'h1111, 1'b0);
    wait_done("bp_first", 16'h5432, 1'b0, 1'b0, 1'b0);
    A        = 16'h0100;
    B        = 16'h0020;
    SUB      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_S", {16'b0, S}, 32'h5432);
      check("bp_CO", {31'b0, CO}, 32'd0);
      check("bp_OVF", {31'b0, OVF}, 32'd0);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_after_ack_out_valid", {31'b0, out_valid}, 32'd0);
    issue(16'h0100, 16'h0020, 1'b1);
    wait_done("bp_second", 16'h00E0, 1'b1, 1'b0, 1'b1);

    // Reset during the second RUN cycle aborts the operation
    issue(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_S", {16'b0, S}, 32'h0000);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", {31'b0, seen}, 32'd0);
    issue(16'h0001, 16'h0002, 1'b0);
    wait_done("after_midrst", 16'h0003, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
